collision_scheduler: RTL and testbench
======================================

Name: collision_scheduler

Overview:
Time-multiplexes the single-port map level memory between three movers: player character (id 0), enemy1 (id 1) and enemy2 (id 2). Each mover requests a map-collision check for a proposed sprite position. The scheduler grants requests round-robin and reads the map tile under each of the four sprite corners. It returns a per-requester done pulse and a blocked flag. It sits between the character/enemy logic modules and the map level memory, and is gated by the control module's c_c_enable.

Parameters:
X_W, 9, pixel x coordinate width
Y_W, 8, pixel y coordinate width
MAP_W, 320, map width in pixels
MAP_H, 240, map height in pixels
TILE_SHIFT, 4, log2 of tile edge in pixels (16 px tiles)
SPRITE_S, 16, sprite edge in pixels
MAP_D_W, 2, map tile code width
ADDR_W, 9, map memory address width (must hold (MAP_W>>TILE_SHIFT)*(MAP_H>>TILE_SHIFT))

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
c_c_enable  input  1  allows new grants when high
req  input  3  per-requester request level, bit i = id i
req_x  input  3*X_W  proposed x, slice i = id i
req_y  input  3*Y_W  proposed y, slice i = id i
mem_addr  output  ADDR_W  map memory read address
mem_rd  output  1  map memory read strobe
mem_data  input  MAP_D_W  tile code, valid the cycle after mem_rd
done  output  3  one-cycle completion pulse per requester
blocked  output  3  collision result per requester, updated with done[i]
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset, including mid-transaction: state=IDLE, done=0, blocked=0, mem_rd=0, mem_addr=0, busy=0, round-robin pointer=0. The in-flight result is discarded; no done pulse is issued.
- States: IDLE, READ, WAIT, DONE.
- IDLE: if c_c_enable && |req, pick the winner by round-robin, latch its x/y, set corner k=0 and go to READ. Otherwise stay in IDLE.
  - Round-robin: priority starts at the pointer and proceeds pointer, pointer+1, pointer+2 (mod 3). After DONE, the pointer is set to winner+1 mod 3.
- Corner order: k0=(x,y), k1=(x+SPRITE_S-1,y), k2=(x,y+SPRITE_S-1), k3=(x+SPRITE_S-1,y+SPRITE_S-1).
  - Corner sums are computed one bit wider than the coordinate, so overflow cannot wrap.
- A corner is out of bounds (OOB) if cx>=MAP_W or cy>=MAP_H.
- Address: addr = (cy>>TILE_SHIFT)*(MAP_W>>TILE_SHIFT) + (cx>>TILE_SHIFT).
- READ:
  - Corner OOB: set blocked result and go to DONE; no mem_rd.
  - Otherwise: mem_addr=addr and mem_rd=1 for this cycle only, then go to WAIT.
- WAIT: sample mem_data. A tile is solid when mem_data != 0.
  - Solid: set blocked result and go to DONE (early out).
  - Not solid, k==3: go to DONE with result 0.
  - Not solid, k<3: k++ and go to READ.
- DONE: done[winner]=1 for exactly one cycle; blocked[winner] takes the result; other blocked bits hold. Then go to IDLE.
- Latency, counted in edges after the accepting edge: all four corners free and in bounds, done is visible after 8 edges. Early out at corner k, done after 2k+2 edges. OOB at corner k, done after 2k+1 edges.
- Requests and enable:
  - req is a level signal; a request dropped before grant is ignored.
  - The winner's req still high in DONE is re-arbitrated in IDLE at the moved pointer priority.
  - Coordinates are latched at grant, so later req_x/req_y changes do not affect an in-flight check.
  - c_c_enable low blocks only new grants; an in-flight check completes.
- mem_addr holds its last value outside READ.

Decomposition:
- Shared package (collision_pkg): requester ID constants (ID_CHAR=0, ID_E1=1, ID_E2=2), state encoding, map geometry constants (MAP_W, MAP_H, TILE_SHIFT, derived MAP_COLS=MAP_W>>TILE_SHIFT).
- One sub-module: collision_rr_arbiter. It holds the 3-way round-robin pointer, takes req and enable, outputs a winner id plus valid, and accepts an advance strobe from DONE.

Test Plan:
- After reset, req=001, x0=32, y0=48, map all 0 -> four mem_rd pulses all at addr 62; done=001 after 8 edges; blocked=000.
- req=001, x0=40, y0=48, tile 63=1 -> reads addr 62 then 63; done[0] after 4 edges; blocked[0]=1; only 2 mem_rd pulses.
- req=100, x2=310, y2=0 -> one read at addr 19; corner1 x=325 is OOB; done[2] after 3 edges; blocked[2]=1.
- req=111 held continuously, map all 0 -> grants in order 0,1,2,0,1,2; exactly one done bit per transaction; busy drops for exactly one IDLE cycle between transactions.
- c_c_enable=0 with req=010 -> no mem_rd and busy=0 for 20 cycles. Raise enable -> grant next edge.
- Grant id 1 (x1=40, y1=48, tile 63=1), assert reset in WAIT -> next cycle all outputs 0, done never pulses for that check. A fresh req=010 after reset completes with blocked=010.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared definitions for the map-collision scheduler.
// Holds the requester ids, the scheduler state encoding and the default
// map geometry used by the scheduler and its round-robin arbiter.
package collision_pkg;

    // Requester ids; they also index req/done/blocked bits.
    localparam logic [1:0] ID_CHAR = 2'd0;
    localparam logic [1:0] ID_E1   = 2'd1;
    localparam logic [1:0] ID_E2   = 2'd2;

    // Default map geometry (pixels; tiles are 2**TILE_SHIFT pixels square).
    localparam int MAP_W      = 320;
    localparam int MAP_H      = 240;
    localparam int TILE_SHIFT = 4;
    localparam int MAP_COLS   = MAP_W >> TILE_SHIFT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/collision_rr_arbiter.sv
// Three-way round-robin arbiter for the collision scheduler.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   req[2:0]      : request levels, bit i = requester id i
//   enable        : win_valid can only rise while enable is high
//   advance       : one-cycle strobe, moves the pointer past advance_id
//   advance_id    : id of the requester that just finished
//   win_id        : highest-priority requesting id (pointer first)
//   win_valid     : enable and at least one request present
module collision_rr_arbiter
    import collision_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       enable,
    input  logic       advance,
    input  logic [1:0] advance_id,
    output logic [1:0] win_id,
    output logic       win_valid
);

    logic [1:0] ptr_q;
    logic [1:0] cand1;
    logic [1:0] cand2;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == ID_E2) ? ID_CHAR : id + 2'd1;
    endfunction

    always_comb begin
        cand1     = next_id(ptr_q);
        cand2     = next_id(cand1);
        win_valid = enable && (|req);
        if (req[ptr_q])
            win_id = ptr_q;
        else if (req[cand1])
            win_id = cand1;
        else
            win_id = cand2;
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr_q <= ID_CHAR;
        else if (advance)
            ptr_q <= next_id(advance_id);
    end

endmodule

// File: rtl/collision_scheduler.sv
// Time-multiplexes the single-port map level memory between the player
// character (id 0) and two enemies (ids 1, 2). A granted mover has the map
// tile under each of its four sprite corners read in turn; any solid tile or
// out-of-map corner ends the check early with a blocked result.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   c_c_enable    : allows new grants when high
//   req[2:0]      : per-requester request level
//   req_x, req_y  : proposed sprite position, slice i = requester i
//   mem_addr      : map memory read address (holds outside READ)
//   mem_rd        : map memory read strobe
//   mem_data      : tile code, valid the cycle after mem_rd
//   done[2:0]     : one-cycle completion pulse per requester
//   blocked[2:0]  : collision result per requester, updated with done
//   busy          : high whenever a check is in progress
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int MAP_W      = collision_pkg::MAP_W,
    parameter int MAP_H      = collision_pkg::MAP_H,
    parameter int TILE_SHIFT = collision_pkg::TILE_SHIFT,
    parameter int SPRITE_S   = 16,
    parameter int MAP_D_W    = 2,
    parameter int ADDR_W     = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 c_c_enable,
    input  logic [2:0]           req,
    input  logic [3*X_W-1:0]     req_x,
    input  logic [3*Y_W-1:0]     req_y,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [MAP_D_W-1:0]   mem_data,
    output logic [2:0]           done,
    output logic [2:0]           blocked,
    output logic                 busy
);

    localparam int COLS = MAP_W >> TILE_SHIFT;
    // One extra bit so the far-corner sum can never wrap back into the map.
    localparam int CX_W = X_W + 1;
    localparam int CY_W = Y_W + 1;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          k_q;
    logic [1:0]          win_q;
    logic [1:0]          arb_id;
    logic                arb_valid;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [CX_W-1:0]     cx;
    logic [CY_W-1:0]     cy;
    logic                oob;
    logic [ADDR_W-1:0]   corner_addr;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [2:0]          blocked_q;
    logic                grant;
    logic                step;
    logic                finish;
    logic                finish_blk;
    logic                advance;

    collision_rr_arbiter u_arb (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .enable     (c_c_enable),
        .advance    (advance),
        .advance_id (win_q),
        .win_id     (arb_id),
        .win_valid  (arb_valid)
    );

    // Corner k: bit 0 selects the right edge, bit 1 the bottom edge.
    always_comb begin
        cx          = {1'b0, x_q} + (k_q[0] ? CX_W'(SPRITE_S - 1) : '0);
        cy          = {1'b0, y_q} + (k_q[1] ? CY_W'(SPRITE_S - 1) : '0);
        oob         = (cx >= CX_W'(MAP_W)) || (cy >= CY_W'(MAP_H));
        corner_addr = ADDR_W'(32'(cy >> TILE_SHIFT) * COLS + 32'(cx >> TILE_SHIFT));
    end

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        finish_blk = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (oob) begin
                    finish     = 1'b1;
                    finish_blk = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_data != '0) begin
                    finish     = 1'b1;
                    finish_blk = 1'b1;
                    state_d    = DONE;
                end else if (k_q == 2'd3) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step    = 1'b1;
                    state_d = READ;
                end
            end
            DONE: begin
                advance = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd   = (state_q == READ) && !oob;
    assign mem_addr = mem_rd ? corner_addr : addr_hold_q;
    assign done     = (state_q == DONE) ? (3'b001 << win_q) : 3'b000;
    assign blocked  = blocked_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            blocked_q   <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant)
                k_q <= '0;
            else if (step)
                k_q <= k_q + 2'd1;
            if (mem_rd)
                addr_hold_q <= corner_addr;
            // Result lands on the edge into DONE so blocked lines up with done.
            if (finish)
                blocked_q[win_q] <= finish_blk;
        end
    end

    // Winner and coordinates are captured at grant; later req_x/req_y
    // changes cannot disturb the check in flight.
    always_ff @(posedge clock) begin
        if (grant) begin
            win_q <= arb_id;
            x_q   <= req_x[arb_id*X_W +: X_W];
            y_q   <= req_y[arb_id*Y_W +: Y_W];
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
module tb_collision_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_c_enable;
    logic [2:0]  req;
    logic [26:0] req_x;
    logic [23:0] req_y;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic [1:0]  mem_data;
    logic [2:0]  done;
    logic [2:0]  blocked;
    logic        busy;

    logic [1:0]  map [0:511];

    typedef struct {
        int   id;
        logic blk;
    } exp_t;

    exp_t        sb[$];
    int          exp_addr[$];
    logic [2:0]  exp_blocked;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    collision_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .c_c_enable (c_c_enable),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .done       (done),
        .blocked    (blocked),
        .busy       (busy)
    );

    // Map memory: one-cycle read latency; garbage when no read was issued.
    always_ff @(posedge clock) mem_data <= mem_rd ? map[mem_addr] : 2'b11;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: read addresses and completions against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_rd) begin
                    if (exp_addr.size() == 0)
                        chk("extra_rd", 1, 0);
                    else
                        chk("rd_addr", 32'(mem_addr), exp_addr.pop_front());
                end
                if (done != 3'b000) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'(done), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_id", 32'(done), 32'(3'b001 << e.id));
                        exp_blocked[e.id] = e.blk;
                        chk("blocked", 32'(blocked), 32'(exp_blocked));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_map();
        for (int i = 0; i < 512; i++) map[i] = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clock);
        @(negedge clock);
        reset       = 1'b0;
        exp_blocked = 3'b000;
        sb.delete();
        exp_addr.delete();
    endtask

    task automatic set_pos(input int id, input int x, input int y);
        req_x[id*9 +: 9] = 9'(x);
        req_y[id*8 +: 8] = 8'(y);
    endtask

    task automatic expect_txn(input int id, input logic blk, input int n,
                              input int a0, input int a1, input int a2, input int a3);
        int a[4];
        exp_t e;
        a = '{a0, a1, a2, a3};
        e.id  = id;
        e.blk = blk;
        sb.push_back(e);
        for (int i = 0; i < n; i++) exp_addr.push_back(a[i]);
    endtask

    // Call just before the accepting edge; measures edges until done.
    task automatic finish_txn(input int lat);
        int got;
        got = -1;
        @(posedge clock);
        #1;
        chk("grant_busy", 32'(busy), 1);
        req = 3'b000;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #1;
            if (done != 3'b000) begin
                got = e;
                break;
            end
        end
        chk("latency", got, lat);
        @(negedge clock);
        chk("rd_left", exp_addr.size(), 0);
    endtask

    task automatic do_txn(input int id, input int x, input int y, input logic blk,
                          input int lat, input int n,
                          input int a0, input int a1, input int a2, input int a3);
        @(negedge clock);
        set_pos(id, x, y);
        req     = 3'b000;
        req[id] = 1'b1;
        expect_txn(id, blk, n, a0, a1, a2, a3);
        finish_txn(lat);
    endtask

    initial begin
        int ndone;
        int idle_run;
        int cnt;

        reset       = 1'b1;
        c_c_enable  = 1'b1;
        req         = 3'b000;
        req_x       = '0;
        req_y       = '0;
        exp_blocked = 3'b000;
        clear_map();

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_done", 32'(done), 0);
        chk("rst_blocked", 32'(blocked), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Single checks: free, early out, OOB, edge-of-map cases
        do_txn(0, 32, 48, 1'b0, 8, 4, 62, 62, 62, 62);
        map[63] = 2'b01;
        do_txn(0, 40, 48, 1'b1, 4, 2, 62, 63, 0, 0);
        map[63] = 2'b00;
        do_txn(2, 310, 0, 1'b1, 3, 1, 19, 0, 0, 0);
        do_txn(1, 304, 224, 1'b0, 8, 4, 299, 299, 299, 299);
        do_txn(1, 0, 225, 1'b1, 5, 2, 280, 280, 0, 0);
        do_txn(0, 511, 100, 1'b1, 1, 0, 0, 0, 0, 0);
        map[83] = 2'b11;
        do_txn(2, 40, 56, 1'b1, 8, 4, 62, 63, 82, 83);
        map[83] = 2'b00;
        do_txn(2, 32, 48, 1'b0, 8, 4, 62, 62, 62, 62);

        // Round-robin with all requests held
        do_reset();
        for (int i = 0; i < 3; i++) set_pos(i, 32, 48);
        for (int t = 0; t < 6; t++) expect_txn(t % 3, 1'b0, 4, 62, 62, 62, 62);
        req      = 3'b111;
        ndone    = 0;
        idle_run = 0;
        for (int c = 0; c < 200 && ndone < 6; c++) begin
            @(negedge clock);
            if (done != 3'b000) begin
                ndone++;
                chk("rr_onehot", $countones(done), 1);
                if (ndone == 6) req = 3'b000;
            end
            if (!busy) begin
                idle_run++;
            end else begin
                if (ndone > 0 && idle_run > 0) chk("rr_idle_gap", idle_run, 1);
                idle_run = 0;
            end
        end
        chk("rr_count", ndone, 6);
        @(negedge clock);
        chk("rr_sb_left", sb.size(), 0);

        // Enable low holds off new grants
        @(negedge clock);
        c_c_enable = 1'b0;
        set_pos(1, 32, 48);
        req = 3'b010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("en_no_rd", 32'(mem_rd), 0);
            chk("en_no_busy", 32'(busy), 0);
        end
        c_c_enable = 1'b1;
        expect_txn(1, 1'b0, 4, 62, 62, 62, 62);
        finish_txn(8);

        // Reset while waiting on the first tile
        map[63] = 2'b01;
        @(negedge clock);
        set_pos(1, 40, 48);
        req = 3'b010;
        exp_addr.push_back(62);
        @(posedge clock);
        #1;
        chk("mid_grant", 32'(busy), 1);
        req = 3'b000;
        @(posedge clock);
        #1;
        chk("mid_wait", 32'(busy), 1);
        chk("mid_rd_seen", exp_addr.size(), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_blocked = 3'b000;
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_blocked", 32'(blocked), 0);
        chk("mid_rst_mem_rd", 32'(mem_rd), 0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done != 3'b000) cnt++;
        end
        chk("mid_no_done", cnt, 0);
        do_txn(1, 40, 48, 1'b1, 4, 2, 62, 63, 0, 0);
        chk("mid_final_blocked", 32'(blocked), 32'(3'b010));

        @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
